// File: rtl/exception_ctrl_if.sv
// Commit-stage bundle between the pipeline, the exception arbiter and CP0.
// The pipeline/CP0 side uses the master modport and the arbiter uses the slave modport.
interface exception_ctrl_if #(
  parameter int WIDTH = 32
);
  // Commit stage
  logic             commit_valid;
  logic             commit_ready;
  logic [WIDTH-1:0] commit_pc;
  logic             commit_bd;
  logic             commit_eret;
  logic [6:0]       exc_flags;
  logic [WIDTH-1:0] fetch_vaddr;
  logic [WIDTH-1:0] data_vaddr;

  // CP0 state that the arbiter reads
  logic             status_ie;
  logic             status_exl;
  logic [7:0]       status_im;
  logic [7:0]       int_pending;
  logic [WIDTH-1:0] epc_in;

  // CP0 write side
  logic             cp0_exc_we;
  logic             cp0_badv_we;
  logic [4:0]       cp0_exc_code;
  logic [WIDTH-1:0] cp0_epc;
  logic             cp0_bd;
  logic [WIDTH-1:0] cp0_badvaddr;
  logic             cp0_eret;

  // Pipeline control
  logic             flush;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, commit_bd, commit_eret, exc_flags,
           fetch_vaddr, data_vaddr, status_ie, status_exl, status_im,
           int_pending, epc_in,
    input  commit_ready, cp0_exc_we, cp0_badv_we, cp0_exc_code, cp0_epc,
           cp0_bd, cp0_badvaddr, cp0_eret, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_eret, exc_flags,
           fetch_vaddr, data_vaddr, status_ie, status_exl, status_im,
           int_pending, epc_in,
    output commit_ready, cp0_exc_we, cp0_badv_we, cp0_exc_code, cp0_epc,
           cp0_bd, cp0_badvaddr, cp0_eret, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt arbiter in front of CP0: picks the winning cause, pulses
// the CP0 write strobes, holds flush for FLUSH_CYCLES cycles, then redirects fetch.
module exception_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int               FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_t;

  // Flag bit positions inside exc_flags = {adel_if,ri,ov,sys,bp,adel_d,ades}
  localparam int F_ADEL_IF = 6;
  localparam int F_RI      = 5;
  localparam int F_OV      = 4;
  localparam int F_SYS     = 3;
  localparam int F_BP      = 2;
  localparam int F_ADEL_D  = 1;
  localparam int F_ADES    = 0;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic             r_exc_we;
  logic             r_badv_we;
  logic             r_eret;
  exc_code_t        r_exc_code;
  logic [WIDTH-1:0] r_epc;
  logic             r_bd;
  logic [WIDTH-1:0] r_badvaddr;
  logic [WIDTH-1:0] r_redirect_pc;

  logic             w_int_take;
  logic             w_any_exc;
  logic             w_is_eret;
  logic             w_capture;
  exc_code_t        w_exc_code;
  logic             w_badv_we;
  logic [WIDTH-1:0] w_badvaddr;

  // Interrupts are only eligible while enabled and not already inside a handler.
  assign w_int_take = bus.status_ie & ~bus.status_exl & (|(bus.int_pending & bus.status_im));
  assign w_any_exc  = w_int_take | (|bus.exc_flags);
  // An ERET that also carries a fault is handled as that fault.
  assign w_is_eret  = bus.commit_eret & ~w_any_exc;

  // Cause selection, highest priority first.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    w_exc_code = EXC_INT;
    w_badv_we  = 1'b0;
    w_badvaddr = '0;
    if (w_int_take) begin
      w_exc_code = EXC_INT;
    end else if (bus.exc_flags[F_ADEL_IF]) begin
      w_exc_code = EXC_ADEL;
      w_badv_we  = 1'b1;
      w_badvaddr = bus.fetch_vaddr;
    end else if (bus.exc_flags[F_RI]) begin
      w_exc_code = EXC_RI;
    end else if (bus.exc_flags[F_OV]) begin
      w_exc_code = EXC_OV;
    end else if (bus.exc_flags[F_SYS]) begin
      w_exc_code = EXC_SYS;
    end else if (bus.exc_flags[F_BP]) begin
      w_exc_code = EXC_BP;
    end else if (bus.exc_flags[F_ADEL_D]) begin
      w_exc_code = EXC_ADEL;
      w_badv_we  = 1'b1;
      w_badvaddr = bus.data_vaddr;
    end else if (bus.exc_flags[F_ADES]) begin
      w_exc_code = EXC_ADES;
      w_badv_we  = 1'b1;
      w_badvaddr = bus.data_vaddr;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.commit_valid && (w_any_exc || bus.commit_eret)) begin
          w_state_next = S_FLUSH;
          w_capture    = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_next = S_REDIRECT;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_REDIRECT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register here is a control/datapath flop
    // (no memories), so all are cleared to give a deterministic post-reset view.
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_exc_we      <= 1'b0;
      r_badv_we     <= 1'b0;
      r_eret        <= 1'b0;
      r_exc_code    <= EXC_INT;
      r_epc         <= '0;
      r_bd          <= 1'b0;
      r_badvaddr    <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_capture ? CNT_W'(FLUSH_CYCLES - 1) : w_cnt_next;
      r_exc_we  <= w_capture & ~w_is_eret;
      r_eret    <= w_capture & w_is_eret;
      r_badv_we <= w_capture & ~w_is_eret & w_badv_we;
      if (w_capture) begin
        r_redirect_pc <= w_is_eret ? bus.epc_in : EXC_VECTOR;
        // CP0 cause fields only change when an exception is actually recorded.
        if (!w_is_eret) begin
          r_exc_code <= w_exc_code;
          r_epc      <= bus.commit_pc;
          r_bd       <= bus.commit_bd;
          r_badvaddr <= w_badvaddr;
        end
      end
    end
  end

  assign bus.commit_ready   = (r_state == S_IDLE);
  assign bus.flush          = (r_state != S_IDLE);
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;

  assign bus.cp0_exc_we     = r_exc_we;
  assign bus.cp0_badv_we    = r_badv_we;
  assign bus.cp0_eret       = r_eret;
  assign bus.cp0_exc_code   = r_exc_code;
  assign bus.cp0_epc        = r_epc;
  assign bus.cp0_bd         = r_bd;
  assign bus.cp0_badvaddr   = r_badvaddr;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: each task drives one scenario and compares against
// hand-computed values, with FLUSH_CYCLES=2 so redirect lands three cycles after commit.
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exception_ctrl_if #(.WIDTH(32)) bus ();

  exception_ctrl #(
    .WIDTH       (32),
    .EXC_VECTOR  (VEC),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle snapshots, index = cycles after the commit edge.
  logic        ob_exc_we [1:4];
  logic        ob_badv_we[1:4];
  logic        ob_eret   [1:4];
  logic [4:0]  ob_code   [1:4];
  logic [31:0] ob_epc    [1:4];
  logic        ob_bd     [1:4];
  logic [31:0] ob_badv   [1:4];
  logic        ob_flush  [1:4];
  logic        ob_rv     [1:4];
  logic [31:0] ob_rpc    [1:4];
  logic        ob_ready  [1:4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.commit_valid = 1'b0;
    bus.commit_pc    = '0;
    bus.commit_bd    = 1'b0;
    bus.commit_eret  = 1'b0;
    bus.exc_flags    = '0;
    bus.fetch_vaddr  = '0;
    bus.data_vaddr   = '0;
    bus.status_ie    = 1'b0;
    bus.status_exl   = 1'b0;
    bus.status_im    = '0;
    bus.int_pending  = '0;
    bus.epc_in       = '0;
  endtask

  // Present one commit for a single cycle and snapshot the four following cycles.
  task automatic commit_and_observe();
    bus.commit_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.commit_valid = 1'b0;
      ob_exc_we[c]  = bus.cp0_exc_we;
      ob_badv_we[c] = bus.cp0_badv_we;
      ob_eret[c]    = bus.cp0_eret;
      ob_code[c]    = bus.cp0_exc_code;
      ob_epc[c]     = bus.cp0_epc;
      ob_bd[c]      = bus.cp0_bd;
      ob_badv[c]    = bus.cp0_badvaddr;
      ob_flush[c]   = bus.flush;
      ob_rv[c]      = bus.redirect_valid;
      ob_rpc[c]     = bus.redirect_pc;
      ob_ready[c]   = bus.commit_ready;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.commit_ready); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
    checks++; if (bus.cp0_exc_we !== 1'b0 || bus.cp0_eret !== 1'b0 || bus.cp0_badv_we !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got we=%b eret=%b badv=%b exp 0", bus.cp0_exc_we, bus.cp0_eret, bus.cp0_badv_we); end
    checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL reset_redirect got v=%b pc=%h exp 0", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.cp0_exc_code !== 5'h00 || bus.cp0_epc !== 32'h0) begin
      errors++; $display("FAIL reset_cp0 got code=%h epc=%h exp 0", bus.cp0_exc_code, bus.cp0_epc); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    bus.commit_pc = 32'h80001000;
    bus.exc_flags = 7'b0010000;
    commit_and_observe();
    checks++; if (ob_exc_we[1] !== 1'b1) begin errors++; $display("FAIL ov_exc_we_n1 got %b exp 1", ob_exc_we[1]); end
    checks++; if (ob_code[1] !== 5'h0C) begin errors++; $display("FAIL ov_code got %h exp 0c", ob_code[1]); end
    checks++; if (ob_epc[1] !== 32'h80001000 || ob_bd[1] !== 1'b0) begin
      errors++; $display("FAIL ov_epc got %h bd=%b exp 80001000 bd=0", ob_epc[1], ob_bd[1]); end
    checks++; if (ob_badv_we[1] !== 1'b0 || ob_eret[1] !== 1'b0) begin
      errors++; $display("FAIL ov_side_pulses got badv=%b eret=%b exp 0", ob_badv_we[1], ob_eret[1]); end
    checks++; if (ob_flush[1] !== 1'b1 || ob_ready[1] !== 1'b0) begin
      errors++; $display("FAIL ov_flush_n1 got flush=%b ready=%b exp 1/0", ob_flush[1], ob_ready[1]); end
    checks++; if (ob_exc_we[2] !== 1'b0 || ob_flush[2] !== 1'b1 || ob_rv[2] !== 1'b0) begin
      errors++; $display("FAIL ov_n2 got we=%b flush=%b rv=%b exp 0/1/0", ob_exc_we[2], ob_flush[2], ob_rv[2]); end
    checks++; if (ob_rv[3] !== 1'b1 || ob_rpc[3] !== VEC || ob_flush[3] !== 1'b1) begin
      errors++; $display("FAIL ov_redirect_n3 got rv=%b pc=%h flush=%b exp 1/bfc00380/1", ob_rv[3], ob_rpc[3], ob_flush[3]); end
    checks++; if (ob_rv[4] !== 1'b0 || ob_flush[4] !== 1'b0 || ob_ready[4] !== 1'b1) begin
      errors++; $display("FAIL ov_idle_n4 got rv=%b flush=%b ready=%b exp 0/0/1", ob_rv[4], ob_flush[4], ob_ready[4]); end
    checks++; if (ob_code[4] !== 5'h0C || ob_epc[4] !== 32'h80001000) begin
      errors++; $display("FAIL ov_held got code=%h epc=%h exp 0c/80001000", ob_code[4], ob_epc[4]); end
  endtask

  task automatic test_priority();
    bus.commit_pc  = 32'h80001234;
    bus.commit_bd  = 1'b1;
    bus.exc_flags  = 7'b0101001;
    bus.data_vaddr = 32'hDEAD0001;
    commit_and_observe();
    checks++; if (ob_exc_we[1] !== 1'b1 || ob_code[1] !== 5'h0A) begin
      errors++; $display("FAIL prio_ri got we=%b code=%h exp 1/0a", ob_exc_we[1], ob_code[1]); end
    checks++; if (ob_bd[1] !== 1'b1 || ob_epc[1] !== 32'h80001234) begin
      errors++; $display("FAIL prio_bd got bd=%b epc=%h exp 1/80001234", ob_bd[1], ob_epc[1]); end
    checks++; if (ob_badv_we[1] !== 1'b0) begin errors++; $display("FAIL prio_badv_we got %b exp 0", ob_badv_we[1]); end
  endtask

  task automatic test_address_errors();
    bus.commit_pc  = 32'h80000010;
    bus.exc_flags  = 7'b0000010;
    bus.data_vaddr = 32'h00000003;
    commit_and_observe();
    checks++; if (ob_code[1] !== 5'h04 || ob_badv[1] !== 32'h3 || ob_badv_we[1] !== 1'b1) begin
      errors++; $display("FAIL adel_d got code=%h badv=%h we=%b exp 04/3/1", ob_code[1], ob_badv[1], ob_badv_we[1]); end
    checks++; if (ob_badv_we[2] !== 1'b0) begin errors++; $display("FAIL adel_d_pulse got %b exp 0", ob_badv_we[2]); end

    bus.exc_flags  = 7'b0000001;
    bus.data_vaddr = 32'h00000102;
    commit_and_observe();
    checks++; if (ob_code[1] !== 5'h05 || ob_badv[1] !== 32'h102 || ob_badv_we[1] !== 1'b1) begin
      errors++; $display("FAIL ades got code=%h badv=%h we=%b exp 05/102/1", ob_code[1], ob_badv[1], ob_badv_we[1]); end

    // adel_if outranks adel_d and selects the fetch address.
    bus.exc_flags   = 7'b1000010;
    bus.fetch_vaddr = 32'h00001001;
    bus.data_vaddr  = 32'h00000003;
    commit_and_observe();
    checks++; if (ob_code[1] !== 5'h04 || ob_badv[1] !== 32'h1001 || ob_badv_we[1] !== 1'b1) begin
      errors++; $display("FAIL adel_if got code=%h badv=%h we=%b exp 04/1001/1", ob_code[1], ob_badv[1], ob_badv_we[1]); end

    // bp beats adel_d; no BadVAddr write.
    bus.exc_flags = 7'b0000110;
    commit_and_observe();
    checks++; if (ob_code[1] !== 5'h09 || ob_badv_we[1] !== 1'b0) begin
      errors++; $display("FAIL bp_over_adel_d got code=%h badv_we=%b exp 09/0", ob_code[1], ob_badv_we[1]); end

    // sys beats bp.
    bus.exc_flags = 7'b0001100;
    commit_and_observe();
    checks++; if (ob_code[1] !== 5'h08) begin errors++; $display("FAIL sys_over_bp got code=%h exp 08", ob_code[1]); end
  endtask

  task automatic test_interrupt();
    bus.status_ie   = 1'b1;
    bus.status_im   = 8'h80;
    bus.int_pending = 8'h80;
    bus.exc_flags   = 7'b0010000;
    bus.commit_pc   = 32'h80003000;
    commit_and_observe();
    checks++; if (ob_exc_we[1] !== 1'b1 || ob_code[1] !== 5'h00) begin
      errors++; $display("FAIL int_take got we=%b code=%h exp 1/00", ob_exc_we[1], ob_code[1]); end
    checks++; if (ob_rv[3] !== 1'b1 || ob_rpc[3] !== VEC) begin
      errors++; $display("FAIL int_redirect got rv=%b pc=%h exp 1/bfc00380", ob_rv[3], ob_rpc[3]); end

    // Blocked interrupts: exl=1, ie=0, or masked line; plain commit only.
    for (int v = 0; v < 3; v++) begin
      bus.status_ie   = (v != 1);
      bus.status_exl  = (v == 0);
      bus.status_im   = (v == 2) ? 8'h01 : 8'h80;
      bus.int_pending = 8'h80;
      commit_and_observe();
      checks++; if (ob_exc_we[1] !== 1'b0 || ob_flush[1] !== 1'b0 || ob_ready[1] !== 1'b1 || ob_rv[3] !== 1'b0) begin
        errors++; $display("FAIL int_blocked_%0d got we=%b flush=%b ready=%b rv=%b exp 0/0/1/0",
                           v, ob_exc_we[1], ob_flush[1], ob_ready[1], ob_rv[3]); end
    end
  endtask

  task automatic test_eret();
    bus.commit_eret = 1'b1;
    bus.epc_in      = 32'h80002000;
    bus.commit_pc   = 32'h80004000;
    commit_and_observe();
    checks++; if (ob_eret[1] !== 1'b1 || ob_eret[2] !== 1'b0) begin
      errors++; $display("FAIL eret_pulse got n1=%b n2=%b exp 1/0", ob_eret[1], ob_eret[2]); end
    checks++; if ((ob_exc_we[1] | ob_exc_we[2] | ob_exc_we[3] | ob_exc_we[4]) !== 1'b0) begin
      errors++; $display("FAIL eret_no_exc_we got %b%b%b%b exp 0000", ob_exc_we[1], ob_exc_we[2], ob_exc_we[3], ob_exc_we[4]); end
    checks++; if (ob_rv[3] !== 1'b1 || ob_rpc[3] !== 32'h80002000) begin
      errors++; $display("FAIL eret_redirect got rv=%b pc=%h exp 1/80002000", ob_rv[3], ob_rpc[3]); end

    // ERET carrying ri is handled as ri.
    bus.commit_eret = 1'b1;
    bus.exc_flags   = 7'b0100000;
    bus.epc_in      = 32'h80002000;
    commit_and_observe();
    checks++; if (ob_exc_we[1] !== 1'b1 || ob_eret[1] !== 1'b0 || ob_code[1] !== 5'h0A || ob_rpc[3] !== VEC) begin
      errors++; $display("FAIL eret_with_ri got we=%b eret=%b code=%h rpc=%h exp 1/0/0a/bfc00380",
                         ob_exc_we[1], ob_eret[1], ob_code[1], ob_rpc[3]); end
  endtask

  task automatic test_commit_during_flush();
    bus.commit_pc    = 32'h80005000;
    bus.exc_flags    = 7'b0010000;
    bus.commit_valid = 1'b1;
    tick();
    checks++; if (bus.commit_ready !== 1'b0 || bus.cp0_exc_we !== 1'b1) begin
      errors++; $display("FAIL busy_n1 got ready=%b we=%b exp 0/1", bus.commit_ready, bus.cp0_exc_we); end
    bus.commit_pc = 32'h12345678;
    bus.exc_flags = 7'b0100000;
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++; if (bus.cp0_exc_we !== 1'b0 || bus.commit_ready !== 1'b0 || bus.cp0_exc_code !== 5'h0C || bus.cp0_epc !== 32'h80005000) begin
        errors++; $display("FAIL busy_ignore_n%0d got we=%b ready=%b code=%h epc=%h exp 0/0/0c/80005000",
                           c, bus.cp0_exc_we, bus.commit_ready, bus.cp0_exc_code, bus.cp0_epc); end
    end
    clear_inputs();
    tick();
    checks++; if (bus.commit_ready !== 1'b1 || bus.flush !== 1'b0 || bus.cp0_exc_we !== 1'b0) begin
      errors++; $display("FAIL busy_n4 got ready=%b flush=%b we=%b exp 1/0/0", bus.commit_ready, bus.flush, bus.cp0_exc_we); end
  endtask

  task automatic test_reset_mid_flush();
    bus.commit_pc    = 32'h80006000;
    bus.exc_flags    = 7'b0010000;
    bus.commit_valid = 1'b1;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.flush !== 1'b0 || bus.commit_ready !== 1'b1 || bus.cp0_exc_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid got flush=%b ready=%b we=%b exp 0/1/0", bus.flush, bus.commit_ready, bus.cp0_exc_we); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
        errors++; $display("FAIL rst_mid_no_redirect_%0d got rv=%b flush=%b exp 0/0", c, bus.redirect_valid, bus.flush); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_overflow();
    test_priority();
    test_address_errors();
    test_interrupt();
    test_eret();
    test_commit_during_flush();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
